// File: rtl/odd_seq_ctrl_if.sv
// Request/display bus between a run requester and odd_seq_ctrl.
// The controller takes the slave side; the requester (or a bench) takes the master side.
interface odd_seq_ctrl_if #(
    parameter int n = 8
);
    logic         start;
    logic [n-1:0] limit;
    logic         abort;
    logic [n-1:0] data_out;
    logic         ld;
    logic         reg_clr;
    logic         busy;
    logic         done;

    modport master (
        output start, limit, abort,
        input  data_out, ld, reg_clr, busy, done
    );

    modport slave (
        input  start, limit, abort,
        output data_out, ld, reg_clr, busy, done
    );
endinterface

// File: rtl/odd_seq_ctrl.sv
// Drives a loadable register with the odd sequence 1, 3, 5, ... up to a captured limit,
// pacing loads HOLD idle cycles apart; every output is registered.
module odd_seq_ctrl #(
    parameter int n    = 8,
    parameter int HOLD = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    odd_seq_ctrl_if.slave    bus
);
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [n-1:0]  lim_q;
    logic [CW-1:0] hold_cnt;
    logic [n-1:0]  data_q;
    logic          ld_q;
    logic          reg_clr_q;
    logic          busy_q;
    logic          done_q;
    logic [n:0]    next_val;

    // One extra bit keeps the carry so the sequence stops instead of wrapping past 2^n-1.
    assign next_val = {1'b0, data_q} + (n+1)'(2);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            lim_q     <= '0;
            hold_cnt  <= '0;
            data_q    <= '0;
            ld_q      <= 1'b0;
            reg_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ld_q      <= 1'b0;
            reg_clr_q <= 1'b0;
            done_q    <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy_q <= 1'b0;
                        if (bus.start) begin
                            lim_q     <= bus.limit;
                            data_q    <= n'(1);
                            reg_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state     <= CLR;
                        end
                    end
                    CLR: begin
                        if (lim_q == '0) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            ld_q  <= 1'b1;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        hold_cnt <= CW'(HOLD);
                        state    <= WAIT;
                    end
                    WAIT: begin
                        hold_cnt <= hold_cnt - 1'b1;
                        // The cycle that takes the counter to zero is the decision edge.
                        if (hold_cnt == CW'(1)) begin
                            if (next_val[n] || (next_val > {1'b0, lim_q})) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= DONE;
                            end else begin
                                data_q <= next_val[n-1:0];
                                ld_q   <= 1'b1;
                                state  <= LOAD;
                            end
                        end
                    end
                    DONE: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.ld       = ld_q;
    assign bus.reg_clr  = reg_clr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_odd_seq_ctrl.sv
// Directed bench for odd_seq_ctrl: a reference model queues the expected clear/load/done
// events for each run and a negedge monitor pops and compares them as the DUT emits them.
module tb_odd_seq_ctrl;
    localparam int N    = 8;
    localparam int HOLD = 2;

    localparam logic [1:0] EV_CLR  = 2'd0;
    localparam logic [1:0] EV_LD   = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;
    localparam logic [1:0] EV_NONE = 2'd3;

    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] data;
    } ev_t;

    logic clk;
    logic clr_n;
    int   tests_run  = 0;
    int   fail_count = 0;
    int   cyc        = 0;
    int   last_ld    = -1;
    int   done_seen  = 0;
    ev_t  exp_q[$];

    odd_seq_ctrl_if #(.n(N)) bus ();

    odd_seq_ctrl #(.n(N), .HOLD(HOLD)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [N-1:0] lim, input logic a);
        bus.start = s;
        bus.limit = lim;
        bus.abort = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected event stream of a complete run for the given limit.
    task automatic push_run(input int lim);
        ev_t e;
        e.kind = EV_CLR;
        e.data = '0;
        exp_q.push_back(e);
        for (int v = 1; v <= lim && v <= 255; v += 2) begin
            e.kind = EV_LD;
            e.data = N'(v);
            exp_q.push_back(e);
        end
        e.kind = EV_DONE;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input logic [1:0] kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = N'(data);
        exp_q.push_back(e);
    endtask

    // Leaves start low again one cycle later, just after the sampling edge.
    task automatic start_run(input logic [N-1:0] lim);
        applyStimulus(1'b1, lim, 1'b0);
        tick();
        applyStimulus(1'b0, lim, 1'b0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        checkOutput(tag, seen, 1'b1);
    endtask

    always @(negedge clk) begin
        ev_t       e;
        logic [1:0] kind;
        if (clr_n && (bus.ld || bus.reg_clr || bus.done)) begin
            if (bus.reg_clr)  kind = EV_CLR;
            else if (bus.ld)  kind = EV_LD;
            else              kind = EV_DONE;
            checkOutput("ld_reg_clr_exclusive", bus.ld && bus.reg_clr, 1'b0);
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_event", kind, EV_NONE);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_kind", kind, e.kind);
                if (e.kind == EV_LD) checkOutput("sb_data", bus.data_out, e.data);
            end
            if (kind == EV_CLR) last_ld = -1;
            if (kind == EV_DONE) done_seen++;
            if (kind == EV_LD) begin
                if (last_ld >= 0) checkOutput("ld_spacing", cyc - last_ld, HOLD + 1);
                last_ld = cyc;
            end
        end
    end

    initial begin
        applyStimulus(1'b0, '0, 1'b0);
        clr_n = 1'b1;
        #2 clr_n = 1'b0;
        tick();
        checkOutput("reset_data_out", bus.data_out, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_strobes", {bus.ld, bus.reg_clr, bus.done}, 0);
        #2 clr_n = 1'b1;
        tick();

        // Run with limit 7: exact cycle positions of every strobe.
        push_run(7);
        start_run(8'd7);
        checkOutput("t1_reg_clr", bus.reg_clr, 1'b1);
        checkOutput("t1_busy_start", bus.busy, 1'b1);
        checkOutput("t1_data_after_clr", bus.data_out, 1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            checkOutput("t1_ld", bus.ld, (k == 1 || k == 4 || k == 7 || k == 10));
            checkOutput("t1_done", bus.done, (k == 13));
            checkOutput("t1_busy", bus.busy, (k < 13));
            if (k == 10) checkOutput("t1_last_data", bus.data_out, 7);
        end
        tick();
        checkOutput("t1_queue_empty", exp_q.size(), 0);

        // Zero limit: clear then done, no load.
        push_run(0);
        start_run(8'd0);
        checkOutput("t2_reg_clr", bus.reg_clr, 1'b1);
        tick();
        checkOutput("t2_done", bus.done, 1'b1);
        checkOutput("t2_no_ld", bus.ld, 1'b0);
        tick();
        checkOutput("t2_queue_empty", exp_q.size(), 0);

        // Even limit stops at limit-1; full-range limit stops at 255 without wrapping.
        push_run(8);
        start_run(8'd8);
        wait_done("t3_done_8", 40);
        checkOutput("t3_last_8", bus.data_out, 7);
        tick();
        checkOutput("t3_queue_empty_8", exp_q.size(), 0);
        push_run(255);
        start_run(8'd255);
        wait_done("t3_done_255", 1000);
        checkOutput("t3_last_255", bus.data_out, 255);
        repeat (4) tick();
        checkOutput("t3_queue_empty_255", exp_q.size(), 0);

        // Abort in the hold after loading 3.
        push_ev(EV_CLR, 0);
        push_ev(EV_LD, 1);
        push_ev(EV_LD, 3);
        start_run(8'd7);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                tick();
                if (bus.ld && bus.data_out == 8'd3) hit = 1'b1;
            end
            checkOutput("t4_saw_ld3", hit, 1'b1);
        end
        tick();
        applyStimulus(1'b0, 8'd7, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd7, 1'b0);
        checkOutput("t4_busy_after_abort", bus.busy, 1'b0);
        checkOutput("t4_data_kept", bus.data_out, 3);
        repeat (8) tick();
        checkOutput("t4_no_more_events", exp_q.size(), 0);
        checkOutput("t4_data_still_3", bus.data_out, 3);
        // start and abort together in IDLE: start wins.
        push_run(3);
        applyStimulus(1'b1, 8'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd3, 1'b0);
        checkOutput("t4_restart_clr", bus.reg_clr, 1'b1);
        checkOutput("t4_restart_data", bus.data_out, 1);
        wait_done("t4_restart_done", 20);
        tick();
        checkOutput("t4_restart_queue_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a hold interval.
        push_ev(EV_CLR, 0);
        push_ev(EV_LD, 1);
        start_run(8'd7);
        tick();
        tick();
        #3 clr_n = 1'b0;
        #1;
        checkOutput("t5_data_zero", bus.data_out, 0);
        checkOutput("t5_busy_zero", bus.busy, 0);
        checkOutput("t5_strobes_zero", {bus.ld, bus.reg_clr, bus.done}, 0);
        tick();
        #2 clr_n = 1'b1;
        repeat (6) tick();
        checkOutput("t5_idle_busy", bus.busy, 0);
        checkOutput("t5_idle_data", bus.data_out, 0);
        checkOutput("t5_queue_empty", exp_q.size(), 0);

        // A second start with a new limit while busy is ignored.
        done_seen = 0;
        push_run(5);
        start_run(8'd5);
        repeat (3) tick();
        applyStimulus(1'b1, 8'd200, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd200, 1'b0);
        wait_done("t6_done", 40);
        checkOutput("t6_last_data", bus.data_out, 5);
        repeat (10) tick();
        checkOutput("t6_done_once", done_seen, 1);
        checkOutput("t6_queue_empty", exp_q.size(), 0);
        checkOutput("t6_idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
